// File: rtl/note_stream_receiver.sv
`default_nettype none
// ============================================================================
// Module      : note_stream_receiver
// Description : Checks the note-position stream cadence and buffers accepted
//               samples in a show-ahead FIFO for the lane renderer.
// Revision    : 1.0 - initial release
// ============================================================================
module note_stream_receiver #(
    parameter int         DEPTH = 8,
    parameter logic [7:0] START = 8'd120,
    parameter logic [7:0] STOP  = 8'd136,
    parameter logic [7:0] STEP  = 8'd4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     map,
    input  logic                     data_en,
    input  logic [7:0]               data,
    input  logic                     rd,
    output logic [7:0]               q,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     seq_err,
    output logic                     overflow,
    output logic [7:0]               wrap_cnt
);

    localparam int                  c_AW   = $clog2(DEPTH);
    localparam int                  c_CW   = c_AW + 1;
    localparam logic [c_CW-1:0]     c_FULL = c_CW'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [7:0]      r_exp;
    logic            r_seq_err;
    logic            r_overflow;
    logic [7:0]      r_wrap_cnt;

    logic w_acc;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_acc   = map & data_en;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = rd & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = w_acc & (~w_full | w_pop);
    assign w_drop  = w_acc & w_full & ~w_pop;

    // Storage is deliberately not reset; q is undefined until the first push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // The checker resynchronises to every received value, so a single glitch
    // produces exactly one mismatch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp      <= START;
            r_seq_err  <= 1'b0;
            r_overflow <= 1'b0;
            r_wrap_cnt <= '0;
        end else begin
            if (w_acc) begin
                if (data != r_exp) begin
                    r_seq_err <= 1'b1;
                end
                r_exp <= (data == STOP) ? START : data + STEP;
                if (data == STOP) begin
                    r_wrap_cnt <= r_wrap_cnt + 1'b1;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign q        = r_mem[r_rd_ptr];
    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_count;
    assign seq_err  = r_seq_err;
    assign overflow = r_overflow;
    assign wrap_cnt = r_wrap_cnt;

endmodule
`default_nettype wire

// File: tb/tb_note_stream_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_stream_receiver
// Description : Randomised scoreboard bench for note_stream_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_stream_receiver;

    localparam int         c_DEPTH = 8;
    localparam logic [7:0] c_START = 8'd120;
    localparam logic [7:0] c_STOP  = 8'd136;
    localparam logic [7:0] c_STEP  = 8'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       map = 1'b0;
    logic       data_en = 1'b0;
    logic [7:0] data = 8'd0;
    logic       rd = 1'b0;
    logic [7:0] q;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       seq_err;
    logic       overflow;
    logic [7:0] wrap_cnt;

    note_stream_receiver #(
        .DEPTH (c_DEPTH),
        .START (c_START),
        .STOP  (c_STOP),
        .STEP  (c_STEP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .map      (map),
        .data_en  (data_en),
        .data     (data),
        .rd       (rd),
        .q        (q),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .seq_err  (seq_err),
        .overflow (overflow),
        .wrap_cnt (wrap_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: queue of stored samples plus flag/counter state.
    logic [7:0] exp_q[$];
    logic [7:0] m_exp  = c_START;
    bit         m_seq  = 1'b0;
    bit         m_ovf  = 1'b0;
    logic [7:0] m_wrap = 8'd0;

    int n_cmp = 0;
    int n_err = 0;

    // Monitor: pops the scoreboard on every real FIFO pop, then checks status.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset && rd && !empty) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pop_unexpected: q=%0d, required no pop (model empty)", q);
                end else begin
                    logic [7:0] want;
                    want = exp_q.pop_front();
                    if (q !== want) begin
                        n_err++;
                        $display("FAIL q_value: got %0d, required %0d at %0t", q, want, $time);
                    end
                end
            end
            #1;
            n_cmp++;
            if (count !== 4'(exp_q.size()) || empty !== (exp_q.size() == 0) ||
                full !== (exp_q.size() == c_DEPTH)) begin
                n_err++;
                $display("FAIL fifo_status: count=%0d empty=%b full=%b, required count=%0d at %0t",
                         count, empty, full, exp_q.size(), $time);
            end
            n_cmp++;
            if (seq_err !== m_seq || overflow !== m_ovf || wrap_cnt !== m_wrap) begin
                n_err++;
                $display("FAIL flags: seq_err=%b overflow=%b wrap=%0d, required %b %b %0d at %0t",
                         seq_err, overflow, wrap_cnt, m_seq, m_ovf, m_wrap, $time);
            end
        end
    end

    // One clock of stimulus; the model predicts the state after the coming edge.
    task automatic cyc(input bit mp, input bit en, input logic [7:0] d, input bit r);
        bit pop;
        @(negedge clk);
        reset = 1'b0; map = mp; data_en = en; data = d; rd = r;
        pop = r && (exp_q.size() > 0);
        if (mp && en) begin
            if (d != m_exp) m_seq = 1'b1;
            m_exp = (d == c_STOP) ? c_START : 8'(d + c_STEP);
            if (d == c_STOP) m_wrap = m_wrap + 8'd1;
            if (exp_q.size() < c_DEPTH || pop) exp_q.push_back(d);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic rst_cyc(input bit mp, input bit en, input logic [7:0] d, input bit r);
        @(negedge clk);
        reset = 1'b1; map = mp; data_en = en; data = d; rd = r;
        exp_q.delete();
        m_exp = c_START; m_seq = 1'b0; m_ovf = 1'b0; m_wrap = 8'd0;
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'd0, 1'b1);
    endtask

    initial begin
        logic [7:0] seq6 [6] = '{8'd120, 8'd124, 8'd128, 8'd132, 8'd136, 8'd120};
        logic [7:0] glitch [4] = '{8'd120, 8'd124, 8'd200, 8'd204};

        rst_cyc(1'b0, 1'b0, 8'd0, 1'b0);
        rst_cyc(1'b0, 1'b0, 8'd0, 1'b0);

        // Clean sweep, then read it back.
        foreach (seq6[i]) push(seq6[i]);
        drain(7);

        // Gated ticks must be ignored.
        cyc(1'b1, 1'b0, 8'd55, 1'b0);
        cyc(1'b1, 1'b0, 8'd55, 1'b0);
        cyc(1'b0, 1'b1, 8'd55, 1'b0);

        // Single glitch in the cadence.
        rst_cyc(1'b0, 1'b0, 8'd0, 1'b0);
        foreach (glitch[i]) push(glitch[i]);
        drain(5);

        // Overflow, then push+pop while full.
        rst_cyc(1'b0, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 9; i++) push(8'(c_START + ((i % 5) * 4)));
        cyc(1'b1, 1'b1, 8'd136, 1'b1);
        drain(9);

        // Read on empty together with an accept.
        cyc(1'b1, 1'b1, 8'd120, 1'b1);
        drain(2);

        // Mid-stream reset with entries held and an error latched; reset wins.
        push(8'd120); push(8'd99); push(8'd124); push(8'd128); push(8'd132);
        rst_cyc(1'b1, 1'b1, 8'd136, 1'b1);
        push(8'd120);
        drain(2);

        // Random traffic, mostly following the cadence.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 9) < 8) ? m_exp : 8'($urandom);
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0), d,
                ($urandom_range(0, 2) == 0));
            if (i == 300) rst_cyc(1'b0, 1'b0, 8'd0, 1'b0);
        end
        drain(c_DEPTH + 2);

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
